// File: rtl/io_pkg.sv
// Shared definitions for the input-port block: port count, default data
// width and the port-id type used for processor selection.
package io_pkg;

  localparam int NPORTS        = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] port_id_t;

  // One-hot mask with only the bit of the given port set.
  function automatic logic [NPORTS-1:0] port_onehot(input port_id_t id);
    return NPORTS'(1) << id;
  endfunction

endpackage

// File: rtl/io_port_fifo.sv
// Single-port input buffer: DEPTH x WIDTH circular FIFO with occupancy count.
// Pushes are ignored while full and pops are ignored while empty, so the
// caller may drive raw request strobes.
module io_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage write on an accepted push.
  // NOTE: the data array has no reset; the pointers and count decide what is
  // valid, so stale contents are never observable and no reset fan-out is spent.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_input_ports.sv
// Four peripheral input ports, each buffered by its own FIFO, read by the
// processor through a port-select mux. Reads of an empty port raise a sticky
// per-port underrun flag that the processor clears explicitly.
module io_input_ports
  import io_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  ext_data0,
  input  logic [WIDTH-1:0]  ext_data1,
  input  logic [WIDTH-1:0]  ext_data2,
  input  logic [WIDTH-1:0]  ext_data3,
  input  logic [NPORTS-1:0] ext_valid,
  output logic [NPORTS-1:0] ext_ready,
  input  port_id_t          cpu_sel,
  input  logic              cpu_rd,
  output logic [WIDTH-1:0]  cpu_data,
  output logic              cpu_avail,
  input  logic              cpu_clr,
  output logic [NPORTS-1:0] underrun
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0]  w_ext_data [NPORTS];
  logic [WIDTH-1:0]  w_head     [NPORTS];
  logic [CW-1:0]     w_count    [NPORTS];
  logic [NPORTS-1:0] w_full;
  logic [NPORTS-1:0] w_empty;
  logic [NPORTS-1:0] w_push;
  logic [NPORTS-1:0] w_pop;
  logic [NPORTS-1:0] w_underrun_set;
  logic [NPORTS-1:0] r_underrun;

  assign w_ext_data[0] = ext_data0;
  assign w_ext_data[1] = ext_data1;
  assign w_ext_data[2] = ext_data2;
  assign w_ext_data[3] = ext_data3;

  assign ext_ready = ~w_full;
  assign w_push    = ext_valid & ext_ready;
  assign w_pop     = (cpu_rd ? port_onehot(cpu_sel) : '0) & ~w_empty;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    io_port_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push[p]),
      .push_data (w_ext_data[p]),
      .pop       (w_pop[p]),
      .head_data (w_head[p]),
      .count     (w_count[p]),
      .full      (w_full[p]),
      .empty     (w_empty[p])
    );
  end

  // Processor view of the selected port; an empty port reads as zero.
  assign cpu_avail = (w_count[cpu_sel] != '0);
  assign cpu_data  = w_empty[cpu_sel] ? '0 : w_head[cpu_sel];

  assign w_underrun_set = (cpu_rd && w_empty[cpu_sel]) ? port_onehot(cpu_sel) : '0;
  assign underrun       = r_underrun;

  // Sticky underrun flags: a new underrun in the same cycle as a clear survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underrun <= '0;
    end else begin
      r_underrun <= (cpu_clr ? '0 : r_underrun) | w_underrun_set;
    end
  end

endmodule

// File: tb/tb_io_input_ports.sv
// Directed bench for io_input_ports: a vector table for single-cycle
// behaviour plus hand-written sequences for reset and pointer wrap-around.
module tb_io_input_ports;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ext_data0, ext_data1, ext_data2, ext_data3;
  logic [3:0] ext_valid;
  logic [3:0] ext_ready;
  logic [1:0] cpu_sel;
  logic       cpu_rd;
  logic [7:0] cpu_data;
  logic       cpu_avail;
  logic       cpu_clr;
  logic [3:0] underrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  io_input_ports #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ext_data0 (ext_data0),
    .ext_data1 (ext_data1),
    .ext_data2 (ext_data2),
    .ext_data3 (ext_data3),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .cpu_sel   (cpu_sel),
    .cpu_rd    (cpu_rd),
    .cpu_data  (cpu_data),
    .cpu_avail (cpu_avail),
    .cpu_clr   (cpu_clr),
    .underrun  (underrun)
  );

  // One cycle of stimulus and the outputs expected just after its clock edge
  // (cpu_sel still applied).
  typedef struct {
    logic [3:0] valid;
    logic [7:0] data;
    logic [1:0] sel;
    logic       rd;
    logic       clr;
    logic [3:0] exp_ready;
    logic       exp_avail;
    logic [7:0] exp_data;
    logic [3:0] exp_under;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ext_valid = 4'b0000;
    cpu_rd    = 1'b0;
    cpu_clr   = 1'b0;
  endtask

  task automatic check_all_empty(input string tag);
    for (int s = 0; s < 4; s++) begin
      cpu_sel = 2'(s);
      #1;
      check($sformatf("%s_avail_sel%0d", tag, s), 32'(cpu_avail), 32'd0);
      check($sformatf("%s_data_sel%0d", tag, s), 32'(cpu_data), 32'd0);
    end
    check({tag, "_ready"}, 32'(ext_ready), 32'hF);
  endtask

  initial begin
    //          valid    data   sel rd clr  ready    avail data   under
    // single push and pop on port 2
    vecs.push_back('{4'b0100, 8'hA5, 2, 0, 0, 4'b1111, 1, 8'hA5, 4'b0000});
    vecs.push_back('{4'b0000, 8'h00, 2, 1, 0, 4'b1111, 0, 8'h00, 4'b0000});
    // fill port 0, third push held off, drain in order
    vecs.push_back('{4'b0001, 8'h11, 0, 0, 0, 4'b1111, 1, 8'h11, 4'b0000});
    vecs.push_back('{4'b0001, 8'h22, 0, 0, 0, 4'b1110, 1, 8'h11, 4'b0000});
    vecs.push_back('{4'b0001, 8'h33, 0, 0, 0, 4'b1110, 1, 8'h11, 4'b0000});
    vecs.push_back('{4'b0000, 8'h00, 0, 1, 0, 4'b1111, 1, 8'h22, 4'b0000});
    vecs.push_back('{4'b0000, 8'h00, 0, 1, 0, 4'b1111, 0, 8'h00, 4'b0000});
    // full port: push offered with a pop is refused that cycle
    vecs.push_back('{4'b0001, 8'h44, 0, 0, 0, 4'b1111, 1, 8'h44, 4'b0000});
    vecs.push_back('{4'b0001, 8'h55, 0, 0, 0, 4'b1110, 1, 8'h44, 4'b0000});
    vecs.push_back('{4'b0001, 8'h66, 0, 1, 0, 4'b1111, 1, 8'h55, 4'b0000});
    vecs.push_back('{4'b0000, 8'h00, 0, 1, 0, 4'b1111, 0, 8'h00, 4'b0000});
    // port 1: simultaneous push and pop keeps count at 1
    vecs.push_back('{4'b0010, 8'h40, 1, 0, 0, 4'b1111, 1, 8'h40, 4'b0000});
    vecs.push_back('{4'b0010, 8'h41, 1, 1, 0, 4'b1111, 1, 8'h41, 4'b0000});
    vecs.push_back('{4'b0000, 8'h00, 1, 1, 0, 4'b1111, 0, 8'h00, 4'b0000});
    // port 3 underrun, clear, clear colliding with a new underrun
    vecs.push_back('{4'b0000, 8'h00, 3, 1, 0, 4'b1111, 0, 8'h00, 4'b1000});
    vecs.push_back('{4'b0000, 8'h00, 3, 0, 1, 4'b1111, 0, 8'h00, 4'b0000});
    vecs.push_back('{4'b0000, 8'h00, 3, 1, 1, 4'b1111, 0, 8'h00, 4'b1000});
    vecs.push_back('{4'b0000, 8'h00, 3, 0, 1, 4'b1111, 0, 8'h00, 4'b0000});
    // push and read of empty port 3 in the same cycle
    vecs.push_back('{4'b1000, 8'h77, 3, 1, 0, 4'b1111, 1, 8'h77, 4'b1000});
    vecs.push_back('{4'b0000, 8'h00, 3, 1, 1, 4'b1111, 0, 8'h00, 4'b0000});
    // activity on port 0 leaves port 2 untouched
    vecs.push_back('{4'b0100, 8'h99, 2, 0, 0, 4'b1111, 1, 8'h99, 4'b0000});
    vecs.push_back('{4'b0000, 8'h00, 0, 1, 0, 4'b1111, 0, 8'h00, 4'b0001});
    vecs.push_back('{4'b0000, 8'h00, 2, 0, 0, 4'b1111, 1, 8'h99, 4'b0001});
    vecs.push_back('{4'b0000, 8'h00, 2, 1, 1, 4'b1111, 0, 8'h00, 4'b0000});

    // Reset state, observed while reset is still asserted.
    reset     = 1'b1;
    ext_data0 = 8'h00;
    ext_data1 = 8'h00;
    ext_data2 = 8'h00;
    ext_data3 = 8'h00;
    cpu_sel   = 2'd0;
    drive_idle();
    #12;
    check("reset_ready", 32'(ext_ready), 32'hF);
    check("reset_avail", 32'(cpu_avail), 32'd0);
    check("reset_data", 32'(cpu_data), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single-cycle vectors.
    foreach (vecs[i]) begin
      @(negedge clk);
      ext_valid = vecs[i].valid;
      ext_data0 = vecs[i].data;
      ext_data1 = vecs[i].data;
      ext_data2 = vecs[i].data;
      ext_data3 = vecs[i].data;
      cpu_sel   = vecs[i].sel;
      cpu_rd    = vecs[i].rd;
      cpu_clr   = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(ext_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_avail", i), 32'(cpu_avail), 32'(vecs[i].exp_avail));
      check($sformatf("vec%0d_data", i), 32'(cpu_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_under));
    end

    // Load all four ports, then reset mid-operation with pushes still offered.
    @(negedge clk);
    drive_idle();
    ext_valid = 4'b1111;
    ext_data0 = 8'h10;
    ext_data1 = 8'h11;
    ext_data2 = 8'h12;
    ext_data3 = 8'h13;
    @(posedge clk);
    #1;
    ext_valid = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      cpu_sel = 2'(s);
      #1;
      check($sformatf("load_data_sel%0d", s), 32'(cpu_data), 32'h10 + 32'(s));
      check($sformatf("load_avail_sel%0d", s), 32'(cpu_avail), 32'd1);
    end
    // Leave an underrun pending on port 3 to be wiped by reset.
    @(negedge clk);
    cpu_sel = 2'd3;
    cpu_rd  = 1'b1;
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_sel = 2'd3;
    @(negedge clk);
    cpu_rd = 1'b1;
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    check("pre_reset_underrun", 32'(underrun), 32'h8);
    ext_valid = 4'b1111;
    reset     = 1'b1;
    #1;
    check("async_reset_underrun", 32'(underrun), 32'd0);
    check_all_empty("in_reset");
    @(negedge clk);
    ext_valid = 4'b0000;
    reset     = 1'b0;
    #1;
    check_all_empty("post_reset");

    // Streaming push/pop on port 2 through several pointer wraps.
    @(negedge clk);
    ext_valid = 4'b0100;
    ext_data2 = 8'h30;
    cpu_sel   = 2'd2;
    cpu_rd    = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("wrap_data%0d", i), 32'(cpu_data), 32'h30 + 32'(i));
      check($sformatf("wrap_avail%0d", i), 32'(cpu_avail), 32'd1);
      ext_valid = 4'b0100;
      ext_data2 = 8'(8'h31 + i);
      cpu_rd    = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    check("wrap_last_data", 32'(cpu_data), 32'h3A);
    ext_valid = 4'b0000;
    cpu_rd    = 1'b1;
    @(posedge clk);
    #1;
    check("wrap_drained_avail", 32'(cpu_avail), 32'd0);
    check("wrap_drained_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    drive_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
